hw_accumulator: RTL and testbench
=================================

Name: hw_accumulator

Overview:
- Hardware accumulate stage between the debounced button/switch inputs and the two 4-digit hex display drivers.
- Adds the 16-bit switch value into a 32-bit running sum on each accumulate press. Holding the button auto-repeats the add.
- Drives the 32-bit value shown on the hex displays, plus a sticky overflow flag. Frees the soft processor from polling for accumulate.

Parameters:
- DATA_W, 32, width of running sum.
- SW_W, 16, width of switch operand; zero-extended to DATA_W.
- HOLD_CYCLES, 50_000_000, cycles from first add to first auto-repeat add (0.5 s at 100 MHz); must be >= 2.
- REPEAT_CYCLES, 10_000_000, cycles between auto-repeat adds; must be >= 1.

Ports:
- clk  in  1  100 MHz system clock.
- reset_n  in  1  asynchronous, active-low reset.
- acc_btn  in  1  debounced accumulate button, 1 = pressed.
- clr_btn  in  1  debounced clear button, 1 = pressed, level-sensitive.
- sw  in  SW_W  debounced switch operand.
- sum  out  DATA_W  running sum, registered; feeds the hex drivers (upper 16 bits to display 0, lower 16 bits to display 1).
- overflow  out  1  sticky carry-out flag.
- acc_pulse  out  1  one-cycle strobe, high in the cycle the updated sum first appears.

Behaviour:
- Reset (reset_n = 0, async) forces:
  - sum = 0, overflow = 0, acc_pulse = 0.
  - State = IDLE, timer = 0.
  - acc_btn_q = 1, so a button held through reset causes no add until it is released and pressed again.
- acc_btn_q is acc_btn registered every cycle. A rise is acc_btn = 1 && acc_btn_q = 0.
- Add operation: {carry, sum} <= sum + zero_ext(sw).
  - Sum wraps modulo 2^DATA_W.
  - carry = 1 sets overflow; overflow stays set until clear or reset.
- Latency: the add happens on the clock edge that samples the rise. The new sum and acc_pulse = 1 are visible the following cycle. acc_pulse is high for exactly 1 cycle per add.
- FSM states are IDLE, HOLD, REPEAT.
  - IDLE: on a rise, add, timer <= 0, go to HOLD.
  - HOLD: while acc_btn = 1, timer increments. When timer == HOLD_CYCLES-1, add, timer <= 0, go to REPEAT.
  - REPEAT: while acc_btn = 1, timer increments. When timer == REPEAT_CYCLES-1, add, timer <= 0.
  - HOLD or REPEAT with acc_btn = 0: go to IDLE, timer <= 0, no add.
- Add timing for a press first sampled at edge T0:
  - adds occur at T0, T0+HOLD_CYCLES, then every REPEAT_CYCLES after that while held.
- Clear (clr_btn = 1, any state):
  - sum <= 0, overflow <= 0, acc_pulse <= 0, held every cycle it is asserted.
  - Clear beats a coincident add; that add is discarded, not deferred.
  - FSM and timer continue, so auto-repeat adds resume after clear is released if acc_btn is still held.
- sw is sampled on the add edge only. Changes between adds have no effect on the sum.
- Timer width is the number of bits needed to hold max(HOLD_CYCLES, REPEAT_CYCLES). The timer never wraps.

Optional Feature:
- Macro ACC_AUTO_REPEAT_EN.
- Defined: full IDLE/HOLD/REPEAT behaviour as above.
- Undefined:
  - HOLD, REPEAT and the timer are not built.
  - Exactly one add per rise of acc_btn; holding the button adds nothing further.
  - HOLD_CYCLES and REPEAT_CYCLES are ignored.
  - All other behaviour is identical.

Test Plan:
- Bench parameters: HOLD_CYCLES = 8, REPEAT_CYCLES = 4, macro defined unless noted.
- Single press: sw = 0x0005, press acc_btn for 3 cycles -> sum = 0x00000005 one cycle after the rise; acc_pulse high exactly 1 cycle; no further change after release.
- Auto-repeat: sw = 0x0001, hold acc_btn for 20 cycles -> adds at T0, T0+8, T0+12, T0+16; sum = 4; four acc_pulse strobes.
- Wrap/overflow:
  - Preload sum = 0xFFFFFFF0 by repeated adds or force; sw = 0x0020, press -> sum = 0x00000010, overflow = 1.
  - Further press with sw = 1 -> overflow remains 1.
- Clear priority: acc_btn rise in the same cycle as clr_btn = 1, sum nonzero -> sum = 0, overflow = 0, acc_pulse stays 0.
- Reset mid-operation:
  - Assert reset_n = 0 asynchronously in REPEAT -> sum, overflow, acc_pulse go to 0 immediately.
  - Release reset with acc_btn still 1 -> no add until acc_btn goes 0 and then 1.
- Macro undefined: sw = 0x0003, hold acc_btn for 30 cycles -> sum = 0x00000003 with a single acc_pulse.

Source files
------------

// File: rtl/hw_accumulator.sv
// Button-driven 32-bit accumulator for the hex display path, with sticky carry-out.
// Define ACC_AUTO_REPEAT_EN to build the hold/auto-repeat FSM; otherwise one add per press.
module hw_accumulator #(
   parameter int unsigned DATA_W        = 32,
   parameter int unsigned SW_W          = 16,
   parameter int unsigned HOLD_CYCLES   = 50_000_000,
   parameter int unsigned REPEAT_CYCLES = 10_000_000
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              acc_btn,
   input  logic              clr_btn,
   input  logic [SW_W-1:0]   sw,
   output logic [DATA_W-1:0] sum,
   output logic              overflow,
   output logic              acc_pulse
);

   // Reject configurations the timer compare or zero-extension cannot represent
   if (SW_W > DATA_W || HOLD_CYCLES < 2 || REPEAT_CYCLES < 1) begin : g_bad_params
      $error("hw_accumulator: invalid parameter combination");
   end

   logic            acc_btn_q;
   logic            rise_c;
   logic            add_c;
   logic [DATA_W:0] add_res_c;

   // Resets high so a button held through reset needs a fresh press
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) acc_btn_q <= 1'b1;
      else          acc_btn_q <= acc_btn;
   end

   assign rise_c = acc_btn && !acc_btn_q;

`ifdef ACC_AUTO_REPEAT_EN
   localparam int unsigned TIMER_MAX   = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES
                                                                      : REPEAT_CYCLES;
   localparam int unsigned TIMER_W     = $clog2(TIMER_MAX + 1);
   localparam logic [TIMER_W-1:0] HOLD_LAST   = TIMER_W'(HOLD_CYCLES - 1);
   localparam logic [TIMER_W-1:0] REPEAT_LAST = TIMER_W'(REPEAT_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      HOLD   = 2'd1,
      REPEAT = 2'd2
   } state_t;

   state_t             state, state_nxt;
   logic [TIMER_W-1:0] timer, timer_nxt;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
         timer <= '0;
      end else begin
         state <= state_nxt;
         timer <= timer_nxt;
      end
   end

   // Timer stops at the compare value and restarts, so it never wraps
   always_comb begin
      state_nxt = state;
      timer_nxt = timer;
      case (state)
         IDLE: begin
            if (rise_c) begin
               state_nxt = HOLD;
               timer_nxt = '0;
            end
         end
         HOLD: begin
            if (!acc_btn) begin
               state_nxt = IDLE;
               timer_nxt = '0;
            end else if (timer == HOLD_LAST) begin
               state_nxt = REPEAT;
               timer_nxt = '0;
            end else begin
               timer_nxt = timer + TIMER_W'(1);
            end
         end
         REPEAT: begin
            if (!acc_btn) begin
               state_nxt = IDLE;
               timer_nxt = '0;
            end else if (timer == REPEAT_LAST) begin
               timer_nxt = '0;
            end else begin
               timer_nxt = timer + TIMER_W'(1);
            end
         end
         default: begin
            state_nxt = IDLE;
            timer_nxt = '0;
         end
      endcase
   end

   always_comb begin
      add_c = 1'b0;
      case (state)
         IDLE:    add_c = rise_c;
         HOLD:    add_c = acc_btn && (timer == HOLD_LAST);
         REPEAT:  add_c = acc_btn && (timer == REPEAT_LAST);
         default: add_c = 1'b0;
      endcase
   end
`else
   always_comb begin
      add_c = rise_c;
   end
`endif

   assign add_res_c = {1'b0, sum} + (DATA_W + 1)'(sw);

   // Clear wins over a coincident add; that add is dropped
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sum       <= '0;
         overflow  <= 1'b0;
         acc_pulse <= 1'b0;
      end else if (clr_btn) begin
         sum       <= '0;
         overflow  <= 1'b0;
         acc_pulse <= 1'b0;
      end else if (add_c) begin
         sum       <= add_res_c[DATA_W-1:0];
         overflow  <= overflow | add_res_c[DATA_W];
         acc_pulse <= 1'b1;
      end else begin
         acc_pulse <= 1'b0;
      end
   end

endmodule

// File: tb/tb_hw_accumulator.sv
// Directed bench for hw_accumulator with HOLD_CYCLES=8, REPEAT_CYCLES=4.
// Expectations follow ACC_AUTO_REPEAT_EN the same way the design does.
module tb_hw_accumulator;

   localparam int unsigned HOLD   = 8;
   localparam int unsigned REPEAT = 4;
`ifdef ACC_AUTO_REPEAT_EN
   localparam bit AUTO = 1'b1;
`else
   localparam bit AUTO = 1'b0;
`endif

   logic        clk;
   logic        reset_n;
   logic        acc_btn;
   logic        clr_btn;
   logic [15:0] sw;
   logic [31:0] sum;
   logic        overflow;
   logic        acc_pulse;

   int          n_tests;
   int          n_fail;
   logic [31:0] exp_sum;

   typedef struct {
      string       name;
      logic        acc;
      logic        clr;
      logic [15:0] sw;
      logic [31:0] sum;
      logic        ovf;
      logic        pulse;
   } vec_t;

   vec_t vecs[13];

   hw_accumulator #(
      .DATA_W       (32),
      .SW_W         (16),
      .HOLD_CYCLES  (HOLD),
      .REPEAT_CYCLES(REPEAT)
   ) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .acc_btn  (acc_btn),
      .clr_btn  (clr_btn),
      .sw       (sw),
      .sum      (sum),
      .overflow (overflow),
      .acc_pulse(acc_pulse)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] e_sum,
                        input logic e_ovf, input logic e_pulse);
      n_tests++;
      if ({sum, overflow, acc_pulse} !== {e_sum, e_ovf, e_pulse}) begin
         n_fail++;
         $display("FAIL %s: got sum=%h ovf=%b pulse=%b, expected sum=%h ovf=%b pulse=%b",
                  name, sum, overflow, acc_pulse, e_sum, e_ovf, e_pulse);
      end
   endtask

   // Hold the button n cycles; optional one-cycle clear at cycle clr_at
   task automatic hold_seq(input string name, input logic [15:0] s, input int n,
                           input int clr_at, input bit rel);
      logic add;
      logic pulse;
      for (int k = 0; k < n; k++) begin
         acc_btn = 1'b1;
         sw      = s;
         clr_btn = (k == clr_at);
         step();
         add = (k == 0) ||
               (AUTO && k >= int'(HOLD) && ((k - int'(HOLD)) % int'(REPEAT)) == 0);
         if (k == clr_at) begin
            exp_sum = '0;
            pulse   = 1'b0;
         end else if (add) begin
            exp_sum = exp_sum + 32'(s);
            pulse   = 1'b1;
         end else begin
            pulse   = 1'b0;
         end
         check($sformatf("%s k=%0d", name, k), exp_sum, 1'b0, pulse);
      end
      clr_btn = 1'b0;
      if (rel) begin
         acc_btn = 1'b0;
         step();
         check($sformatf("%s release", name), exp_sum, 1'b0, 1'b0);
      end
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      exp_sum = '0;
      reset_n = 1'b0;
      acc_btn = 1'b0;
      clr_btn = 1'b0;
      sw      = '0;

      vecs[0]  = '{"idle",        1'b0, 1'b0, 16'h0005, 32'h0000_0000, 1'b0, 1'b0};
      vecs[1]  = '{"press5",      1'b1, 1'b0, 16'h0005, 32'h0000_0005, 1'b0, 1'b1};
      vecs[2]  = '{"held1",       1'b1, 1'b0, 16'h0005, 32'h0000_0005, 1'b0, 1'b0};
      vecs[3]  = '{"held_swchg",  1'b1, 1'b0, 16'h0009, 32'h0000_0005, 1'b0, 1'b0};
      vecs[4]  = '{"release",     1'b0, 1'b0, 16'h0009, 32'h0000_0005, 1'b0, 1'b0};
      vecs[5]  = '{"press10",     1'b1, 1'b0, 16'h0010, 32'h0000_0015, 1'b0, 1'b1};
      vecs[6]  = '{"release2",    1'b0, 1'b0, 16'h0010, 32'h0000_0015, 1'b0, 1'b0};
      vecs[7]  = '{"clr_vs_add",  1'b1, 1'b1, 16'h0007, 32'h0000_0000, 1'b0, 1'b0};
      vecs[8]  = '{"held_noadd",  1'b1, 1'b0, 16'h0007, 32'h0000_0000, 1'b0, 1'b0};
      vecs[9]  = '{"release3",    1'b0, 1'b0, 16'h0007, 32'h0000_0000, 1'b0, 1'b0};
      vecs[10] = '{"press3",      1'b1, 1'b0, 16'h0003, 32'h0000_0003, 1'b0, 1'b1};
      vecs[11] = '{"clear",       1'b0, 1'b1, 16'h0003, 32'h0000_0000, 1'b0, 1'b0};
      vecs[12] = '{"idle2",       1'b0, 1'b0, 16'h0003, 32'h0000_0000, 1'b0, 1'b0};

      #1;
      check("reset", 32'h0, 1'b0, 1'b0);
      step();
      step();
      reset_n = 1'b1;

      foreach (vecs[i]) begin
         acc_btn = vecs[i].acc;
         clr_btn = vecs[i].clr;
         sw      = vecs[i].sw;
         step();
         check(vecs[i].name, vecs[i].sum, vecs[i].ovf, vecs[i].pulse);
      end
      clr_btn = 1'b0;

      // Wrap and sticky overflow from a preloaded sum
      force dut.sum = 32'hFFFF_FFF0;
      #1;
      release dut.sum;
      #1;
      check("preload", 32'hFFFF_FFF0, 1'b0, 1'b0);
      acc_btn = 1'b1; sw = 16'h0020; step();
      check("wrap", 32'h0000_0010, 1'b1, 1'b1);
      acc_btn = 1'b0; step();
      check("wrap_idle", 32'h0000_0010, 1'b1, 1'b0);
      acc_btn = 1'b1; sw = 16'h0001; step();
      check("ovf_sticky", 32'h0000_0011, 1'b1, 1'b1);
      acc_btn = 1'b0; step();
      check("ovf_hold", 32'h0000_0011, 1'b1, 1'b0);
      clr_btn = 1'b1; step();
      check("ovf_clear", 32'h0, 1'b0, 1'b0);
      clr_btn = 1'b0; step();
      exp_sum = '0;

      hold_seq("hold20", 16'h0001, 20, -1, 1'b1);
      check("hold20_total", AUTO ? 32'd4 : 32'd1, 1'b0, 1'b0);
      clr_btn = 1'b1; step(); clr_btn = 1'b0;
      exp_sum = '0;
      hold_seq("hold30", 16'h0003, 30, -1, 1'b1);
      check("hold30_total", AUTO ? 32'd21 : 32'd3, 1'b0, 1'b0);
      hold_seq("hold_clr", 16'h0002, 20, 12, 1'b1);

      // Async reset while auto-repeating, button held across release
      clr_btn = 1'b1; step(); clr_btn = 1'b0;
      exp_sum = '0;
      hold_seq("pre_rst", 16'h0001, 11, -1, 1'b0);
      #2;
      reset_n = 1'b0;
      #1;
      check("async_rst", 32'h0, 1'b0, 1'b0);
      step();
      reset_n = 1'b1;
      for (int k = 0; k < 12; k++) begin
         step();
         check($sformatf("held_after_rst k=%0d", k), 32'h0, 1'b0, 1'b0);
      end
      acc_btn = 1'b0; step();
      check("rst_release_btn", 32'h0, 1'b0, 1'b0);
      acc_btn = 1'b1; step();
      check("rst_repress", 32'h1, 1'b0, 1'b1);
      acc_btn = 1'b0; step();
      check("rst_repress_idle", 32'h1, 1'b0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
